led_pwm_fader: RTL

- Downstream stage of the blinky LED pattern generator; consumes its 6-bit `led` vector.
- Drives the board LED pins through per-LED PWM with a global brightness setting and optional linear fade (breathing) between off and on.
- Pin polarity is set by parameter, for boards with active-low LEDs.
- Sits between the pattern logic and the top-level pin assignments.

---
 rtl/led_pkg.sv | 17 +
 rtl/led_fade_channel.sv | 60 ++++++
 rtl/led_pwm_fader.sv | 70 +++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED PWM fader.
package led_pkg;

   typedef enum logic [1:0] {OFF, RISE, ON, FALL} fade_state_t;

   localparam int N_LEDS_DEF   = 6;
   localparam int PWM_BITS_DEF = 8;

   // Clocks per fade step so that a full 0..2^pwm_bits ramp takes ramp_us microseconds.
   function automatic int calc_fade_div(input longint clk_hz, input longint ramp_us,
                                        input int pwm_bits);
      longint steps;
      steps = longint'(1) << pwm_bits;
      return int'((clk_hz * ramp_us) / (longint'(1_000_000) * steps));
   endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: fade state machine, level register and per-period duty latch.
module led_fade_channel
   import led_pkg::*;
#(
   parameter int PWM_BITS = PWM_BITS_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                led_in,
   input  logic [PWM_BITS-1:0] brightness,
   input  logic                fade_en,
   input  logic                fade_tick,
   input  logic                period_start,
   output logic [PWM_BITS-1:0] duty_q
);

   localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

   fade_state_t         state;
   logic [PWM_BITS-1:0] lvl;
   logic [PWM_BITS-1:0] lvl_next;

   // The state is a pure function of the request and the current level.
   always_comb begin
      // NOTE: assign a default before any branch so no path leaves the signal unassigned (latch).
      state = OFF;
      if (led_in) begin
         if (lvl < brightness)       state = RISE;
         else if (lvl == brightness) state = ON;
         else                        state = FALL;
      end else if (lvl != '0) begin
         state = FALL;
      end
   end

   always_comb begin
      lvl_next = lvl;
      if (!fade_en) begin
         lvl_next = led_in ? brightness : '0;
      end else if (fade_tick) begin
         unique case (state)
            RISE:    lvl_next = lvl + ONE;
            FALL:    lvl_next = lvl - ONE;
            default: lvl_next = lvl;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         lvl    <= '0;
         duty_q <= '0;
      end else begin
         lvl <= lvl_next;
         if (period_start) duty_q <= lvl;
      end
   end

endmodule

// File: rtl/led_pwm_fader.sv
// Per-LED PWM with global brightness and optional linear fade; drives the LED pins.
module led_pwm_fader
   import led_pkg::*;
#(
   parameter int N_LEDS     = N_LEDS_DEF,
   parameter int PWM_BITS   = PWM_BITS_DEF,
   parameter int FADE_DIV   = 19531,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_LEDS-1:0]   led_in,
   input  logic [PWM_BITS-1:0] brightness,
   input  logic                fade_en,
   output logic [N_LEDS-1:0]   led_pin,
   output logic                pwm_period_tick
);

   localparam int FDIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
   localparam logic [FDIV_W-1:0]   FDIV_LAST = FDIV_W'(FADE_DIV - 1);
   // Counter stops one short of all-ones so a duty of all-ones lights the whole period.
   localparam logic [PWM_BITS-1:0] CNT_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};

   logic [PWM_BITS-1:0] cnt;
   logic [FDIV_W-1:0]   fdiv;
   logic                period_start;
   logic                fade_tick;
   logic [PWM_BITS-1:0] duty [N_LEDS];

   assign period_start = (cnt == '0);
   assign fade_tick    = (fdiv == FDIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt             <= '0;
         fdiv            <= '0;
         pwm_period_tick <= 1'b0;
      end else begin
         cnt             <= (cnt == CNT_LAST) ? '0 : cnt + PWM_BITS'(1);
         fdiv            <= fade_tick ? '0 : fdiv + FDIV_W'(1);
         pwm_period_tick <= period_start;
      end
   end

   for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
      led_fade_channel #(
         .PWM_BITS(PWM_BITS)
      ) u_ch (
         .clk          (clk),
         .rst_n        (rst_n),
         .led_in       (led_in[i]),
         .brightness   (brightness),
         .fade_en      (fade_en),
         .fade_tick    (fade_tick),
         .period_start (period_start),
         .duty_q       (duty[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_pin <= {N_LEDS{ACTIVE_LOW}};
      end else begin
         for (int i = 0; i < N_LEDS; i++) begin
            led_pin[i] <= (cnt < duty[i]) ^ ACTIVE_LOW;
         end
      end
   end

endmodule
